// File: rtl/comp_result_in.sv
`default_nettype none
// ============================================================================
//  Module      : comp_result_in
//  Description : Avalon-MM slave input mailbox. A hardware producer pushes
//                result words over a valid/ready handshake into a small
//                circular FIFO. The CPU drains them through a four-register
//                CSR window. A level interrupt is raised when data is waiting
//                and/or when the producer was back-pressured.
//  Ports       : clk, reset        - clock, synchronous active-high reset
//                address/chipselect/read_n/write_n/writedata/readdata
//                                  - Avalon-MM CSR slave, zero read latency
//                irq               - level interrupt
//                in_data/in_valid/in_ready - producer stream
//  Registers   : 0 DATA (RO, read pops)   1 STATUS (RO)
//                2 IRQMASK (RW, bits 0,2) 3 CONTROL (WO: bit0 flush,
//                                                    bit2 clear stalled)
//  Revision    : 1.0 - initial release
// ============================================================================
module comp_result_in #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  read_n,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic                  irq,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q,  count_d;
    logic [1:0]            mask_q,   mask_d;    // {stalled enable, not_empty enable}
    logic                  stalled_q, stalled_d;

    logic       w_rd, w_wr, w_push, w_pop, w_flush, w_clr_stall;
    logic       w_full, w_not_empty;
    logic [3:0] w_cnt4;
    logic       w_unused;

    // A simultaneous read and write is treated as a write only, so the read
    // strobe is qualified with write_n high before it can pop.
    assign w_rd        = chipselect & ~read_n & write_n;
    assign w_wr        = chipselect & ~write_n;
    assign w_full      = (count_q == CW'(DEPTH));
    assign w_not_empty = (count_q != '0);

    // in_ready looks only at registered fullness, never at the same-cycle
    // pop, keeping read_n out of the in_ready timing path.
    assign in_ready    = ~w_full & ~reset;
    assign w_push      = in_valid & in_ready;
    assign w_pop       = w_rd & (address == 2'd0) & w_not_empty;
    assign w_flush     = w_wr & (address == 2'd3) & writedata[0];
    assign w_clr_stall = w_wr & (address == 2'd3) & writedata[2];

    assign w_unused    = ^{writedata[31:3], writedata[1]};

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        mask_d    = mask_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (w_flush) begin
            // Empty the FIFO by snapping the read pointer onto the write
            // pointer; a concurrent push lands at wr_ptr_q and survives.
            rd_ptr_d = wr_ptr_q;
            count_d  = w_push ? CW'(1) : '0;
        end else begin
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(w_push) - CW'(w_pop);
        end
        if (w_wr && (address == 2'd2)) begin
            mask_d = {writedata[2], writedata[0]};
        end
        // Set has priority over a same-cycle clear.
        stalled_d = (in_valid & w_full) | (stalled_q & ~w_clr_stall);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            mask_q    <= '0;
            stalled_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            mask_q    <= mask_d;
            stalled_q <= stalled_d;
        end
    end

    // Storage needs no reset: count gates every visible read of it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_comb begin
        w_cnt4           = '0;
        w_cnt4[CW-1:0]   = count_q;
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: begin
                if (w_not_empty) begin
                    readdata = mem_q[rd_ptr_q];
                end
            end
            2'd1: begin
                readdata[0]    = w_not_empty;
                readdata[1]    = w_full;
                readdata[2]    = stalled_q;
                readdata[11:8] = w_cnt4;
            end
            2'd2: begin
                readdata[0] = mask_q[0];
                readdata[2] = mask_q[1];
            end
            default: begin
                readdata = '0;
            end
        endcase
    end

    assign irq = (mask_q[0] & w_not_empty) | (mask_q[1] & stalled_q);

endmodule
`default_nettype wire

// File: tb/tb_comp_result_in.sv
`default_nettype none
// ============================================================================
//  Module      : tb_comp_result_in
//  Description : Self-checking bench for comp_result_in (DEPTH=4). A table of
//                per-cycle CSR/producer stimuli with expected readdata,
//                in_ready and irq, followed by hand-written corner sequences
//                and a queue-based scoreboard over a wrap-around stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_comp_result_in;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;

    comp_result_in #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        v;
        logic [31:0] d;
        logic [31:0] exp_rdata;
        logic        exp_rdy;
        logic        exp_irq;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drives one cycle (called just after a rising edge), samples the
    // combinational outputs late in the cycle, then advances past the edge.
    task automatic cyc(input logic r, input logic w, input logic [1:0] a,
                       input logic [31:0] wd, input logic v, input logic [31:0] d,
                       output logic [31:0] o_rdata, output logic o_rdy, output logic o_irq);
        chipselect = r | w;
        read_n     = ~r;
        write_n    = ~w;
        address    = a;
        writedata  = wd;
        in_valid   = v;
        in_data    = d;
        #7;
        o_rdata = readdata;
        o_rdy   = in_ready;
        o_irq   = irq;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic w, input logic [1:0] a,
                       input logic [31:0] wd, input logic v, input logic [31:0] d,
                       input logic [31:0] er, input logic ey, input logic ei);
        vec_t t;
        t.rd = r; t.wr = w; t.addr = a; t.wdata = wd; t.v = v; t.d = d;
        t.exp_rdata = er; t.exp_rdy = ey; t.exp_irq = ei;
        tbl.push_back(t);
    endtask

    logic [31:0] rdv;
    logic        rdy, irqv;
    logic [31:0] sb[$];

    initial begin
        reset = 1'b1; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
        address = '0; writedata = '0; in_valid = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // ---------------- table: rd wr addr wdata v d | rdata rdy irq
        add(1,0,2'd1,0,0,0,                   32'h0,          1,0);
        add(1,0,2'd2,0,0,0,                   32'h0,          1,0);
        add(1,0,2'd3,0,0,0,                   32'h0,          1,0);
        add(1,0,2'd1,0,1,32'h11111111,        32'h0,          1,0);
        add(1,0,2'd1,0,1,32'h22222222,        32'h101,        1,0);
        add(1,0,2'd1,0,1,32'h33333333,        32'h201,        1,0);
        add(1,0,2'd1,0,1,32'h44444444,        32'h301,        1,0);
        add(1,0,2'd1,0,0,0,                   32'h403,        0,0);
        add(1,0,2'd0,0,0,0,                   32'h11111111,   0,0);
        add(1,0,2'd0,0,0,0,                   32'h22222222,   1,0);
        add(1,0,2'd0,0,0,0,                   32'h33333333,   1,0);
        add(1,0,2'd0,0,0,0,                   32'h44444444,   1,0);
        add(1,0,2'd1,0,0,0,                   32'h0,          1,0);
        add(1,0,2'd0,0,0,0,                   32'h0,          1,0);
        add(1,0,2'd1,0,0,0,                   32'h0,          1,0);
        // back-pressure / stalled
        add(1,0,2'd1,0,1,32'hA0,              32'h0,          1,0);
        add(1,0,2'd1,0,1,32'hA1,              32'h101,        1,0);
        add(1,0,2'd1,0,1,32'hA2,              32'h201,        1,0);
        add(1,0,2'd1,0,1,32'hA3,              32'h301,        1,0);
        add(1,0,2'd1,0,1,32'h55555555,        32'h403,        0,0);
        add(1,0,2'd1,0,1,32'h55555555,        32'h407,        0,0);
        add(1,0,2'd1,0,1,32'h55555555,        32'h407,        0,0);
        add(1,0,2'd0,0,1,32'h55555555,        32'hA0,         0,0);
        add(1,0,2'd1,0,1,32'h55555555,        32'h305,        1,0);
        add(0,1,2'd3,32'h4,0,0,               32'h0,          0,0);
        add(1,0,2'd1,0,0,0,                   32'h403,        0,0);
        add(1,0,2'd0,0,0,0,                   32'hA1,         0,0);
        add(1,0,2'd0,0,0,0,                   32'hA2,         1,0);
        add(1,0,2'd0,0,0,0,                   32'hA3,         1,0);
        add(1,0,2'd0,0,0,0,                   32'h55555555,   1,0);
        add(1,0,2'd1,0,0,0,                   32'h0,          1,0);
        // interrupts
        add(0,1,2'd2,32'h1,0,0,               32'h0,          1,0);
        add(1,0,2'd2,0,1,32'hC0,              32'h1,          1,0);
        add(1,0,2'd1,0,0,0,                   32'h101,        1,1);
        add(1,0,2'd0,0,0,0,                   32'hC0,         1,1);
        add(1,0,2'd1,0,0,0,                   32'h0,          1,0);
        add(0,1,2'd2,32'h4,0,0,               32'h1,          1,0);
        add(1,0,2'd2,0,1,32'hD0,              32'h4,          1,0);
        add(1,0,2'd2,0,1,32'hD1,              32'h4,          1,0);
        add(1,0,2'd2,0,1,32'hD2,              32'h4,          1,0);
        add(1,0,2'd2,0,1,32'hD3,              32'h4,          1,0);
        add(1,0,2'd1,0,1,32'hD4,              32'h403,        0,0);
        add(1,0,2'd1,0,0,0,                   32'h407,        0,1);
        add(0,1,2'd3,32'h5,0,0,               32'h0,          0,1);
        add(1,0,2'd1,0,0,0,                   32'h0,          1,0);
        add(0,1,2'd2,32'h0,0,0,               32'h4,          1,0);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].v, tbl[i].d, rdv, rdy, irqv);
            chk($sformatf("vec%0d.readdata", i), rdv, tbl[i].exp_rdata);
            chk($sformatf("vec%0d.in_ready", i), {31'b0, rdy}, {31'b0, tbl[i].exp_rdy});
            chk($sformatf("vec%0d.irq", i), {31'b0, irqv}, {31'b0, tbl[i].exp_irq});
        end

        // ---------------- mid-stream reset at count=3 with mask enabled
        cyc(0,1,2'd2,32'h5,1,32'hE0, rdv, rdy, irqv);
        cyc(0,0,2'd0,0,1,32'hE1, rdv, rdy, irqv);
        cyc(1,0,2'd1,0,1,32'hE2, rdv, rdy, irqv);
        chk("rst.pre_status", rdv, 32'h201);
        reset = 1'b1;
        cyc(0,0,2'd1,0,1,32'hE3, rdv, rdy, irqv);
        chk("rst.in_ready_during_reset", {31'b0, rdy}, 32'h0);
        reset = 1'b0;
        cyc(1,0,2'd1,0,0,0, rdv, rdy, irqv);
        chk("rst.status", rdv, 32'h0);
        chk("rst.in_ready", {31'b0, rdy}, 32'h1);
        chk("rst.irq", {31'b0, irqv}, 32'h0);
        cyc(1,0,2'd2,0,0,0, rdv, rdy, irqv);
        chk("rst.mask", rdv, 32'h0);
        cyc(1,0,2'd0,0,0,0, rdv, rdy, irqv);
        chk("rst.data_empty", rdv, 32'h0);

        // ---------------- simultaneous push and pop at count=2
        cyc(0,0,2'd0,0,1,32'hF0, rdv, rdy, irqv);
        cyc(0,0,2'd0,0,1,32'hF1, rdv, rdy, irqv);
        cyc(1,0,2'd0,0,1,32'hAAAA0001, rdv, rdy, irqv);
        chk("pp.old_head", rdv, 32'hF0);
        cyc(1,0,2'd1,0,0,0, rdv, rdy, irqv);
        chk("pp.count_kept", rdv, 32'h201);
        cyc(1,0,2'd0,0,0,0, rdv, rdy, irqv);
        chk("pp.second", rdv, 32'hF1);
        cyc(1,0,2'd0,0,0,0, rdv, rdy, irqv);
        chk("pp.new_word", rdv, 32'hAAAA0001);

        // ---------------- empty read with concurrent push: no pop
        cyc(1,0,2'd0,0,1,32'h77, rdv, rdy, irqv);
        chk("er.data_zero", rdv, 32'h0);
        cyc(1,0,2'd1,0,0,0, rdv, rdy, irqv);
        chk("er.count1", rdv, 32'h101);
        cyc(1,0,2'd0,0,0,0, rdv, rdy, irqv);
        chk("er.word", rdv, 32'h77);

        // ---------------- flush at count=3 with concurrent push
        cyc(0,0,2'd0,0,1,32'hB0, rdv, rdy, irqv);
        cyc(0,0,2'd0,0,1,32'hB1, rdv, rdy, irqv);
        cyc(0,0,2'd0,0,1,32'hB2, rdv, rdy, irqv);
        cyc(0,1,2'd3,32'h1,1,32'hBEEF0000, rdv, rdy, irqv);
        cyc(1,0,2'd1,0,0,0, rdv, rdy, irqv);
        chk("fl.status", rdv, 32'h101);
        cyc(1,0,2'd0,0,0,0, rdv, rdy, irqv);
        chk("fl.data", rdv, 32'hBEEF0000);
        cyc(1,0,2'd0,0,0,0, rdv, rdy, irqv);
        chk("fl.empty_read", rdv, 32'h0);
        cyc(1,0,2'd1,0,0,0, rdv, rdy, irqv);
        chk("fl.empty_status", rdv, 32'h0);

        // ---------------- scoreboard stream: pointers wrap several times
        begin
            int sent = 0;
            for (int c = 0; c < 300; c++) begin
                logic        r, v;
                logic [31:0] d;
                int          sz;
                if (sent >= 10 && sb.size() == 0) break;
                v  = (sent < 10) && ($urandom_range(0, 3) != 0);
                r  = ($urandom_range(0, 2) != 0);
                d  = 32'hC000_0000 + sent;
                sz = sb.size();
                cyc(r,0,2'd0,0,v,d, rdv, rdy, irqv);
                chk("sb.in_ready", {31'b0, rdy}, {31'b0, (sz < DEPTH)});
                if (r) begin
                    if (sz > 0) begin
                        chk("sb.data", rdv, sb[0]);
                        sb.pop_front();
                    end else begin
                        chk("sb.empty_data", rdv, 32'h0);
                    end
                end
                if (v && sz < DEPTH) begin
                    sb.push_back(d);
                    sent++;
                end
            end
            chk("sb.all_sent", sent, 10);
            chk("sb.drained", sb.size(), 0);
        end
        cyc(1,0,2'd1,0,0,0, rdv, rdy, irqv);
        chk("sb.final_status", rdv, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
